// File: rtl/sap1_controlador_pkg.sv
// -----------------------------------------------------------------------------
// sap1_controlador_pkg
// Shared definitions for the SAP-1 controller-sequencer: opcode constants,
// one-hot T-state constants, the control-word struct and an opcode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package sap1_controlador_pkg;

    localparam int unsigned T_W = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [T_W-1:0] T1 = 6'b000001;
    localparam logic [T_W-1:0] T2 = 6'b000010;
    localparam logic [T_W-1:0] T3 = 6'b000100;
    localparam logic [T_W-1:0] T4 = 6'b001000;
    localparam logic [T_W-1:0] T5 = 6'b010000;
    localparam logic [T_W-1:0] T6 = 6'b100000;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    function automatic logic op_is_defined(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/sap1_controlador_anel_t.sv
// -----------------------------------------------------------------------------
// sap1_anel_t
// Six-bit one-hot ring counter (T1..T6) with an advance enable.
// Ports:
//   clk     - clock, ring moves on rising edge when adv_i = 1
//   rst_n   - asynchronous active-low reset, ring returns to T1
//   adv_i   - advance enable (gated by halt / single-step in the parent)
//   ring_o  - one-hot state, bit0 = T1
// -----------------------------------------------------------------------------
module sap1_anel_t
    import sap1_controlador_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           adv_i,
    output logic [T_W-1:0] ring_o
);

    logic [T_W-1:0] ring_q;
    logic [T_W-1:0] ring_d;

    always_comb begin
        ring_d = ring_q;
        if (adv_i) begin
            ring_d = {ring_q[T_W-2:0], ring_q[T_W-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q <= T1;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring_o = ring_q;

endmodule

// File: rtl/sap1_controlador.sv
// -----------------------------------------------------------------------------
// sap1_controlador
// Controller-sequencer for the SAP-1 datapath. Runs the T1..T6 ring, decodes
// the IR opcode and drives all datapath control lines combinationally from
// (t_state, opcode, halted). HLT freezes the ring at T4 until reset.
// Parameter:
//   HALT_ON_UNDEF - 1: undefined opcodes halt at T4; 0: they are NOPs.
// Optional build macro:
//   SAP1_SINGLE_STEP_EN - adds step_mode/step inputs; in step mode the ring
//                         advances once per synchronised rising edge of step.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   opcode               - IR[7:4], valid from T4
//   step_mode, step      - (SAP1_SINGLE_STEP_EN only) single-step control
//   cp ep lm ce li ei    - PC inc, PC->bus, MAR load, RAM->bus, IR load,
//                          IR low nibble->bus
//   la ea su eu lb lo    - A load, A->bus, subtract, ALU->bus, B load,
//                          output register load
//   t_state              - one-hot ring, bit0 = T1
//   halted               - high while stopped by HLT
// -----------------------------------------------------------------------------
module sap1_controlador
    import sap1_controlador_pkg::*;
#(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     opcode,
`ifdef SAP1_SINGLE_STEP_EN
    input  logic           step_mode,
    input  logic           step,
`endif
    output logic           cp,
    output logic           ep,
    output logic           lm,
    output logic           ce,
    output logic           li,
    output logic           ei,
    output logic           la,
    output logic           ea,
    output logic           su,
    output logic           eu,
    output logic           lb,
    output logic           lo,
    output logic [T_W-1:0] t_state,
    output logic           halted
);

    logic  halted_q;
    logic  halted_d;
    logic  run_en;     // this cycle executes the current T-state
    logic  halt_op;
    logic  at_halt;    // sitting in T4 of a halting instruction
    logic  adv;
    ctrl_t ctrl;

`ifdef SAP1_SINGLE_STEP_EN
    logic step_s1_q;
    logic step_s2_q;
    logic step_s3_q;

    // Two flops for synchronisation, a third to detect the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            step_s3_q <= 1'b0;
        end else begin
            step_s1_q <= step;
            step_s2_q <= step_s1_q;
            step_s3_q <= step_s2_q;
        end
    end

    assign run_en = !step_mode || (step_s2_q && !step_s3_q);
`else
    assign run_en = 1'b1;
`endif

    assign halt_op  = (opcode == OP_HLT) || (HALT_ON_UNDEF && !op_is_defined(opcode));
    assign at_halt  = (t_state == T4) && halt_op;
    // The ring never leaves T4 of a halting instruction.
    assign adv      = run_en && !halted_q && !at_halt;
    assign halted_d = halted_q || (run_en && at_halt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    sap1_anel_t u_anel (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv_i  (adv),
        .ring_o (t_state)
    );

    // su is only ever raised together with eu (SUB T6).
    always_comb begin
        ctrl = '0;
        if (run_en && !halted_q) begin
            case (t_state)
                T1: begin ctrl.ep = 1'b1; ctrl.lm = 1'b1; end
                T2: begin ctrl.cp = 1'b1; end
                T3: begin ctrl.ce = 1'b1; ctrl.li = 1'b1; end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin ctrl.ei = 1'b1; ctrl.lm = 1'b1; end
                        OP_OUT:                 begin ctrl.ea = 1'b1; ctrl.lo = 1'b1; end
                        default:                ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         begin ctrl.ce = 1'b1; ctrl.la = 1'b1; end
                        OP_ADD, OP_SUB: begin ctrl.ce = 1'b1; ctrl.lb = 1'b1; end
                        default:        ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  begin ctrl.eu = 1'b1; ctrl.la = 1'b1; end
                        OP_SUB:  begin ctrl.eu = 1'b1; ctrl.la = 1'b1; ctrl.su = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign cp     = ctrl.cp;
    assign ep     = ctrl.ep;
    assign lm     = ctrl.lm;
    assign ce     = ctrl.ce;
    assign li     = ctrl.li;
    assign ei     = ctrl.ei;
    assign la     = ctrl.la;
    assign ea     = ctrl.ea;
    assign su     = ctrl.su;
    assign eu     = ctrl.eu;
    assign lb     = ctrl.lb;
    assign lo     = ctrl.lo;
    assign halted = halted_q;

endmodule

// File: tb/tb_sap1_controlador.sv
// -----------------------------------------------------------------------------
// tb_sap1_controlador
// Drives a small SAP-1 datapath model from the controller outputs and runs
// LDA/ADD/SUB/OUT/HLT, reset, undefined-opcode and (optionally) single-step
// scenarios. A second instance has HALT_ON_UNDEF = 1.
// -----------------------------------------------------------------------------
module tb_sap1_controlador;

    // Control word bit positions: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    localparam logic [11:0] C_CP = 12'h800;
    localparam logic [11:0] C_EP = 12'h400;
    localparam logic [11:0] C_LM = 12'h200;
    localparam logic [11:0] C_CE = 12'h100;
    localparam logic [11:0] C_LI = 12'h080;
    localparam logic [11:0] C_EI = 12'h040;
    localparam logic [11:0] C_LA = 12'h020;
    localparam logic [11:0] C_EA = 12'h010;
    localparam logic [11:0] C_SU = 12'h008;
    localparam logic [11:0] C_EU = 12'h004;
    localparam logic [11:0] C_LB = 12'h002;
    localparam logic [11:0] C_LO = 12'h001;

    localparam logic [11:0] W_T1 = C_EP | C_LM;
    localparam logic [11:0] W_T2 = C_CP;
    localparam logic [11:0] W_T3 = C_CE | C_LI;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst1_n;
    logic [3:0] opcode;
    logic [3:0] op1;
    wire  [11:0] w0;
    wire  [11:0] w1;
    wire  [5:0]  t0_state;
    wire  [5:0]  t1_state;
    wire         halted0;
    wire         halted1;
`ifdef SAP1_SINGLE_STEP_EN
    logic step_mode;
    logic step;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sap1_controlador #(.HALT_ON_UNDEF(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
`ifdef SAP1_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .cp(w0[11]), .ep(w0[10]), .lm(w0[9]), .ce(w0[8]), .li(w0[7]), .ei(w0[6]),
        .la(w0[5]), .ea(w0[4]), .su(w0[3]), .eu(w0[2]), .lb(w0[1]), .lo(w0[0]),
        .t_state(t0_state), .halted(halted0)
    );

    sap1_controlador #(.HALT_ON_UNDEF(1'b1)) u_dut_h (
        .clk(clk), .rst_n(rst1_n), .opcode(op1),
`ifdef SAP1_SINGLE_STEP_EN
        .step_mode(1'b0), .step(1'b0),
`endif
        .cp(w1[11]), .ep(w1[10]), .lm(w1[9]), .ce(w1[8]), .li(w1[7]), .ei(w1[6]),
        .la(w1[5]), .ea(w1[4]), .su(w1[3]), .eu(w1[2]), .lb(w1[1]), .lo(w1[0]),
        .t_state(t1_state), .halted(halted1)
    );

    // ---------------- datapath model driven by u_dut ----------------
    logic [7:0] ram [16];
    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] ir;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] out_reg;
    logic [7:0] bus;
    logic [7:0] alu;

    assign alu    = w0[3] ? (a_reg - b_reg) : (a_reg + b_reg);
    assign opcode = ir[7:4];

    always_comb begin
        bus = 8'h00;
        if (w0[10]) bus = {4'h0, pc};
        if (w0[8])  bus = ram[mar];
        if (w0[6])  bus = {4'h0, ir[3:0]};
        if (w0[4])  bus = a_reg;
        if (w0[2])  bus = alu;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= 4'h0;
            ir <= 8'h00;
        end else begin
            if (w0[11]) pc      <= pc + 4'h1;
            if (w0[9])  mar     <= bus[3:0];
            if (w0[7])  ir      <= bus;
            if (w0[5])  a_reg   <= bus;
            if (w0[1])  b_reg   <= bus;
            if (w0[0])  out_reg <= bus;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with u_dut in T1; checks ncyc T-states.
    task automatic run_instr(input string name, input logic [11:0] w4,
                             input logic [11:0] w5, input logic [11:0] w6,
                             input int ncyc);
        logic [11:0] exp_w [6];
        exp_w[0] = W_T1; exp_w[1] = W_T2; exp_w[2] = W_T3;
        exp_w[3] = w4;   exp_w[4] = w5;   exp_w[5] = w6;
        for (int k = 0; k < ncyc; k++) begin
            check($sformatf("%s T%0d ctrl", name, k + 1), {20'h0, w0}, {20'h0, exp_w[k]});
            check($sformatf("%s T%0d state", name, k + 1), {26'h0, t0_state}, 32'd1 << k);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        op1    = 4'h7;
`ifdef SAP1_SINGLE_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0] = 8'h09;   // LDA 9
        ram[1] = 8'h1A;   // ADD A
        ram[2] = 8'h2A;   // SUB A
        ram[3] = 8'hE0;   // OUT
        ram[4] = 8'hF0;   // HLT
        ram[9] = 8'h1C;
        ram[10] = 8'h0E;

        #23;
        check("reset state", {26'h0, t0_state}, 32'h01);
        check("reset ctrl",  {20'h0, w0}, {20'h0, W_T1});
        check("reset halted", {31'h0, halted0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("LDA", C_EI | C_LM, C_CE | C_LA, 12'h000, 6);
        check("LDA A", {24'h0, a_reg}, 32'h1C);
        run_instr("ADD", C_EI | C_LM, C_CE | C_LB, C_EU | C_LA, 6);
        check("ADD A", {24'h0, a_reg}, 32'h2A);
        run_instr("SUB", C_EI | C_LM, C_CE | C_LB, C_EU | C_LA | C_SU, 6);
        check("SUB A", {24'h0, a_reg}, 32'h1C);
        run_instr("OUT", C_EA | C_LO, 12'h000, 12'h000, 6);
        check("OUT reg", {24'h0, out_reg}, 32'h1C);
        run_instr("HLT", 12'h000, 12'h000, 12'h000, 4);
        for (int c = 0; c < 22; c++) begin
            check("HLT halted", {31'h0, halted0}, 32'h1);
            check("HLT state", {26'h0, t0_state}, 32'h08);
            check("HLT ctrl", {20'h0, w0}, 32'h0);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("HLT reset state", {26'h0, t0_state}, 32'h01);
        check("HLT reset halted", {31'h0, halted0}, 32'h0);
        check("HLT reset ctrl", {20'h0, w0}, {20'h0, W_T1});
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of ADD T5.
        run_instr("LDA2", C_EI | C_LM, C_CE | C_LA, 12'h000, 6);
        run_instr("ADD2", C_EI | C_LM, C_CE | C_LB, C_EU | C_LA, 4);
        check("ADD2 T5 ctrl", {20'h0, w0}, {20'h0, C_CE | C_LB});
        #2 rst_n = 1'b0;
        #1;
        check("midreset state", {26'h0, t0_state}, 32'h01);
        check("midreset ctrl", {20'h0, w0}, {20'h0, W_T1});
        @(negedge clk);
        rst_n = 1'b1;

        // Undefined opcode 7 as a NOP (HALT_ON_UNDEF = 0).
        ram[0] = 8'h70;
        run_instr("NOP7", 12'h000, 12'h000, 12'h000, 6);
        check("NOP7 wrap state", {26'h0, t0_state}, 32'h01);
        check("NOP7 halted", {31'h0, halted0}, 32'h0);

        // Undefined opcode 7 halts with HALT_ON_UNDEF = 1.
        rst1_n = 1'b1;
        check("H1 T1 ctrl", {20'h0, w1}, {20'h0, W_T1});
        @(negedge clk);
        check("H1 T2 ctrl", {20'h0, w1}, {20'h0, W_T2});
        @(negedge clk);
        check("H1 T3 ctrl", {20'h0, w1}, {20'h0, W_T3});
        @(negedge clk);
        check("H1 T4 ctrl", {20'h0, w1}, 32'h0);
        check("H1 T4 state", {26'h0, t1_state}, 32'h08);
        check("H1 T4 halted", {31'h0, halted1}, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("H1 halted", {31'h0, halted1}, 32'h1);
            check("H1 state", {26'h0, t1_state}, 32'h08);
            check("H1 ctrl", {20'h0, w1}, 32'h0);
        end

`ifdef SAP1_SINGLE_STEP_EN
        begin
            logic [11:0] fetch_w [3];
            int hit;
            int cp_cnt;
            fetch_w[0] = W_T1; fetch_w[1] = W_T2; fetch_w[2] = W_T3;
            rst_n = 1'b0;
            step_mode = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("STEP idle state", {26'h0, t0_state}, 32'h01);
                check("STEP idle ctrl", {20'h0, w0}, 32'h0);
            end
            for (int k = 0; k < 3; k++) begin
                hit = 0;
                cp_cnt = 0;
                step = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    if (c == 6) step = 1'b0;
                    @(negedge clk);
                    if (w0 == fetch_w[k]) hit++;
                    if (w0[11]) cp_cnt++;
                end
                check($sformatf("STEP T%0d pulses", k + 1), hit, 32'd1);
                check($sformatf("STEP T%0d advance", k + 1), {26'h0, t0_state}, 32'd2 << k);
                if (k == 1) check("STEP cp count", cp_cnt, 32'd1);
            end
            step_mode = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
